// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and Register16bit FunSel codes
package fetch_pkg;
   typedef enum logic [2:0] {IDLE, RD_FIRST, RD_SECOND, LOAD, ERR} state_t;
   localparam logic [1:0] FS_DEC  = 2'b00;
   localparam logic [1:0] FS_INC  = 2'b01;
   localparam logic [1:0] FS_LOAD = 2'b10;
   localparam logic [1:0] FS_CLR  = 2'b11;
endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: counts unacknowledged read cycles and flags the cycle that reaches the limit
module fetch_timeout_ctr #(
   parameter int TIMEOUT = 15
) (
   input  logic Clock,
   input  logic Reset,
   input  logic clr,
   input  logic inc,
   output logic expired
);
   localparam int W = $clog2(TIMEOUT + 1);
   logic [W-1:0] cnt;
   // wait counter, saturating so it can never wrap back below the limit
   always_ff @(posedge Clock)
      if (Reset || clr) cnt <= '0;
      else if (inc && cnt != W'(TIMEOUT)) cnt <= cnt + 1'b1;
   // the increment in this cycle is the one that brings the count to TIMEOUT
   assign expired = inc && (cnt == W'(TIMEOUT - 1));
endmodule

// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer: two byte reads at PC, PC increment per byte, one IR load
module instruction_fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int TIMEOUT       = 15,
   parameter bit LITTLE_ENDIAN = 1'b1
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Start,
   input  logic [15:0] PC,
   output logic [15:0] MemAddr,
   output logic        MemRd,
   input  logic        MemAck,
   input  logic [7:0]  MemData,
   output logic        PCE,
   output logic [1:0]  PCFunSel,
   output logic        IRE,
   output logic [1:0]  IRFunSel,
   output logic [15:0] IRData,
   output logic        Busy,
   output logic        Done,
   output logic        Err
);
   state_t      state, state_nxt;
   logic [7:0]  buf0;
   logic [15:0] word;
   logic        rd, expired;
   assign rd = (state == RD_FIRST) || (state == RD_SECOND);
   fetch_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
      .Clock   (Clock),
      .Reset   (Reset),
      .clr     (!rd || MemAck),
      .inc     (rd && !MemAck),
      .expired (expired)
   );
   // state register
   always_ff @(posedge Clock)
      state <= Reset ? IDLE : state_nxt;
   // byte capture; the word is assembled on the second byte so IRData keeps the last complete fetch
   always_ff @(posedge Clock)
      if (Reset) begin
         buf0 <= '0;
         word <= '0;
      end else if (state == RD_FIRST && MemAck) begin
         buf0 <= MemData;
      end else if (state == RD_SECOND && MemAck) begin
         word <= LITTLE_ENDIAN ? {MemData, buf0} : {buf0, MemData};
      end
   // next state and outputs; an acknowledge wins over a simultaneous timeout
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      state_nxt = Start ? RD_FIRST : IDLE;
         RD_FIRST:  state_nxt = MemAck ? RD_SECOND : (expired ? ERR : RD_FIRST);
         RD_SECOND: state_nxt = MemAck ? LOAD : (expired ? ERR : RD_SECOND);
         default:   state_nxt = IDLE;
      endcase
      MemRd    = rd;
      MemAddr  = rd ? PC : 16'h0000;
      PCE      = rd && MemAck;
      PCFunSel = PCE ? FS_INC : FS_DEC;
      IRE      = state == LOAD;
      IRFunSel = IRE ? FS_LOAD : FS_DEC;
      IRData   = word;
      Busy     = state != IDLE;
      Done     = state == LOAD;
      Err      = state == ERR;
   end
endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// tb_instruction_fetch_sequencer: table-driven fetch vectors plus reset/start corner sequences
module tb_instruction_fetch_sequencer;
   import fetch_pkg::*;
   logic        Clock = 1'b0;
   logic        Reset, Start;
   logic [15:0] PC;
   logic        MemAck;
   logic [7:0]  MemData;
   logic [15:0] MemAddr, IRData;
   logic        MemRd, PCE, IRE, Busy, Done, Err;
   logic [1:0]  PCFunSel, IRFunSel;
   logic [15:0] MemAddr2, IRData2;
   logic        MemRd2, PCE2, IRE2, Busy2, Done2, Err2;
   logic [1:0]  PCFunSel2, IRFunSel2;

   instruction_fetch_sequencer #(.TIMEOUT(4), .LITTLE_ENDIAN(1'b1)) dut (
      .Clock(Clock), .Reset(Reset), .Start(Start), .PC(PC), .MemAddr(MemAddr), .MemRd(MemRd),
      .MemAck(MemAck), .MemData(MemData), .PCE(PCE), .PCFunSel(PCFunSel), .IRE(IRE),
      .IRFunSel(IRFunSel), .IRData(IRData), .Busy(Busy), .Done(Done), .Err(Err));
   instruction_fetch_sequencer #(.TIMEOUT(4), .LITTLE_ENDIAN(1'b0)) dut_be (
      .Clock(Clock), .Reset(Reset), .Start(Start), .PC(PC), .MemAddr(MemAddr2), .MemRd(MemRd2),
      .MemAck(MemAck), .MemData(MemData), .PCE(PCE2), .PCFunSel(PCFunSel2), .IRE(IRE2),
      .IRFunSel(IRFunSel2), .IRData(IRData2), .Busy(Busy2), .Done(Done2), .Err(Err2));

   always #5 Clock = ~Clock;

   function automatic logic [7:0] mem_rd(input logic [15:0] a);
      case (a)
         16'h0040: return 8'h34;
         16'h0041: return 8'h12;
         16'h0080: return 8'h78;
         16'h0081: return 8'h56;
         16'hFFFF: return 8'hAB;
         16'h0000: return 8'hCD;
         default:  return 8'h00;
      endcase
   endfunction

   logic [15:0] pc_q = '0, ir_q = '0, ir2_q = '0, pc_set_val = '0;
   logic        pc_set = 1'b0;
   logic [7:0]  wcnt = '0, dly0 = '0, dly1 = '0;
   logic [1:0]  nb = '0;
   assign PC      = pc_q;
   assign MemAck  = MemRd && (wcnt == (nb == 2'd0 ? dly0 : nb == 2'd1 ? dly1 : 8'd0));
   assign MemData = mem_rd(MemAddr);

   always @(posedge Clock) begin
      wcnt <= (!MemRd || MemAck) ? 8'd0 : wcnt + 8'd1;
      if (pc_set) begin
         pc_q <= pc_set_val;
         nb   <= '0;
      end else begin
         if (PCE && PCFunSel == FS_INC) pc_q <= pc_q + 16'd1;
         if (MemAck && nb != 2'd3) nb <= nb + 2'd1;
      end
      if (IRE && IRFunSel == FS_LOAD) ir_q <= IRData;
      if (IRE2 && IRFunSel2 == FS_LOAD) ir2_q <= IRData2;
   end

   int pass_cnt = 0, total_cnt = 0;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: actual=%0h required=%0h", n, act, exp);
      else pass_cnt++;
   endtask

   int          done_cyc, err_cyc, n_done, n_ire, n_rd, n_bad, n_ack;
   logic [15:0] a0, a1;

   task automatic fetch(input logic [15:0] pc0, input logic [7:0] d0, input logic [7:0] d1);
      @(negedge Clock);
      pc_set = 1'b1; pc_set_val = pc0; dly0 = d0; dly1 = d1; Start = 1'b1;
      @(negedge Clock);
      pc_set = 1'b0; Start = 1'b0;
      done_cyc = 0; err_cyc = 0; n_done = 0; n_ire = 0; n_rd = 0; n_bad = 0; n_ack = 0;
      a0 = 16'hDEAD; a1 = 16'hDEAD;
      for (int c = 1; c <= 40; c++) begin
         if (!Busy) break;
         if (Done) begin done_cyc = c; n_done++; end
         if (Err) err_cyc = c;
         if (IRE) n_ire++;
         if (MemRd) n_rd++;
         if (MemAddr !== (MemRd ? pc_q : 16'h0000)) n_bad++;
         if (PCFunSel !== (PCE ? FS_INC : FS_DEC) || IRFunSel !== (IRE ? FS_LOAD : FS_DEC)) n_bad++;
         if (MemAck) begin
            if (n_ack == 0) a0 = MemAddr; else a1 = MemAddr;
            n_ack++;
         end
         @(negedge Clock);
      end
      chk("idle_after_fetch", {31'd0, Busy}, 32'd0);
   endtask

   typedef struct {
      logic [15:0] pc0;
      logic [7:0]  d0, d1;
      logic [15:0] ir, be, pc;
      int          done, err, rd;
      logic [15:0] a0, a1;
   } vec_t;
   vec_t vecs[7];

   initial begin
      vecs[0] = '{16'h0040, 8'd0,   8'd0,   16'h1234, 16'h3412, 16'h0042, 3, 0, 2, 16'h0040, 16'h0041};
      vecs[1] = '{16'h0040, 8'd3,   8'd3,   16'h1234, 16'h3412, 16'h0042, 9, 0, 8, 16'h0040, 16'h0041};
      vecs[2] = '{16'h0080, 8'd0,   8'd255, 16'h1234, 16'h3412, 16'h0081, 0, 6, 5, 16'h0080, 16'hDEAD};
      vecs[3] = '{16'h0080, 8'd3,   8'd0,   16'h5678, 16'h7856, 16'h0082, 6, 0, 5, 16'h0080, 16'h0081};
      vecs[4] = '{16'h0080, 8'd0,   8'd3,   16'h5678, 16'h7856, 16'h0082, 6, 0, 5, 16'h0080, 16'h0081};
      vecs[5] = '{16'h0080, 8'd255, 8'd0,   16'h5678, 16'h7856, 16'h0080, 0, 5, 4, 16'hDEAD, 16'hDEAD};
      vecs[6] = '{16'hFFFF, 8'd0,   8'd0,   16'hCDAB, 16'hABCD, 16'h0001, 3, 0, 2, 16'hFFFF, 16'h0000};
      Reset = 1'b1; Start = 1'b0;
      repeat (2) @(negedge Clock);
      chk("reset_ctrl", {24'd0, MemRd, PCE, IRE, Done, Err, Busy, PCFunSel, IRFunSel}, 32'd0);
      chk("reset_addr", {16'd0, MemAddr}, 32'd0);
      chk("reset_irdata", {IRData, IRData2}, 32'd0);
      Reset = 1'b0;
      for (int i = 0; i < 7; i++) begin
         fetch(vecs[i].pc0, vecs[i].d0, vecs[i].d1);
         chk($sformatf("v%0d_ir", i), {16'd0, ir_q}, {16'd0, vecs[i].ir});
         chk($sformatf("v%0d_ir_be", i), {16'd0, ir2_q}, {16'd0, vecs[i].be});
         chk($sformatf("v%0d_pc", i), {16'd0, pc_q}, {16'd0, vecs[i].pc});
         chk($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].done);
         chk($sformatf("v%0d_done_count", i), n_done, vecs[i].done != 0 ? 1 : 0);
         chk($sformatf("v%0d_ire_count", i), n_ire, vecs[i].done != 0 ? 1 : 0);
         chk($sformatf("v%0d_err_cycle", i), err_cyc, vecs[i].err);
         chk($sformatf("v%0d_rd_cycles", i), n_rd, vecs[i].rd);
         chk($sformatf("v%0d_bad_outputs", i), n_bad, 0);
         chk($sformatf("v%0d_addr0", i), {16'd0, a0}, {16'd0, vecs[i].a0});
         chk($sformatf("v%0d_addr1", i), {16'd0, a1}, {16'd0, vecs[i].a1});
      end
      // reset while waiting in the second read
      @(negedge Clock);
      pc_set = 1'b1; pc_set_val = 16'h0040; dly0 = 8'd0; dly1 = 8'd255; Start = 1'b1;
      @(negedge Clock);
      pc_set = 1'b0; Start = 1'b0;
      @(negedge Clock);
      chk("rst_mid_rd2", {15'd0, MemRd, MemAddr}, {15'd0, 1'b1, 16'h0041});
      Reset = 1'b1;
      @(negedge Clock);
      chk("rst_mid_ctrl", {24'd0, MemRd, PCE, IRE, Done, Err, Busy, PCFunSel, IRFunSel}, 32'd0);
      chk("rst_mid_addr", {16'd0, MemAddr}, 32'd0);
      chk("rst_mid_irdata", {16'd0, IRData}, 32'd0);
      chk("rst_mid_ir_kept", {16'd0, ir_q}, 32'h0000CDAB);
      chk("rst_mid_pc", {16'd0, pc_q}, 32'h00000041);
      Reset = 1'b0;
      // Start held high through LOAD
      @(negedge Clock);
      pc_set = 1'b1; pc_set_val = 16'h0040; dly0 = 8'd0; dly1 = 8'd0; Start = 1'b1;
      @(negedge Clock);
      pc_set = 1'b0;
      repeat (2) @(negedge Clock);
      chk("hold_done_c3", {30'd0, Done, IRE}, 32'd3);
      @(negedge Clock);
      chk("hold_idle_c4", {30'd0, Busy, MemRd}, 32'd0);
      chk("hold_pc_c4", {16'd0, pc_q}, 32'h00000042);
      @(negedge Clock);
      chk("hold_restart_c5", {15'd0, MemRd, MemAddr}, {15'd0, 1'b1, 16'h0042});
      Start = 1'b0;
      for (int c = 0; c < 20 && Busy; c++) @(negedge Clock);
      chk("hold_idle_end", {31'd0, Busy}, 32'd0);
      chk("hold_pc_end", {16'd0, pc_q}, 32'h00000044);
      chk("hold_ir_end", {16'd0, ir_q}, 32'h00000000);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
